sha_block_scheduler: RTL

- Shares one SHA compression core between NumReq independent requesters, one 512-bit block at a time.
- Drives the core's block, enable and reset controls and tracks its idle/hold status.
- Locks the core to one requester for a whole multi-block message.
- Sits between requester front-ends (DMA, register interfaces) and the hash core.

---
 rtl/sha_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/sha_block_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// Shared definitions for the SHA block scheduler: FSM state encoding and
// default sizing for the block width and the BUSY watchdog.
package sha_pkg;

    localparam int BlockWidthDef    = 512;
    localparam int TimeoutCyclesDef = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_RESET,
        ST_LAUNCH,
        ST_BUSY,
        ST_DONE,
        ST_WAIT_NEXT
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts one position after
// ptr and wraps, so the most recent winner has the lowest priority.
module rr_arbiter #(
    parameter int NumReq = 4,
    parameter int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   ptr,
    output logic [NumReq-1:0] gnt_oh,
    output logic [IdxW-1:0]   gnt_idx,
    output logic              gnt_valid
);

    logic [IdxW-1:0] cand;

    // Pick the first requester found scanning from ptr+1 around to ptr.
    always_comb begin
        gnt_oh    = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NumReq; k++) begin
            cand = IdxW'((int'(ptr) + k) % NumReq);
            if (!gnt_valid && req[cand]) begin
                gnt_valid     = 1'b1;
                gnt_idx       = cand;
                gnt_oh[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha_block_scheduler.sv
// Shares one SHA compression core among NumReq requesters, one block at a
// time. A requester keeps the core locked for the whole multi-block message;
// a watchdog aborts a job that stays BUSY too long.
module sha_block_scheduler
    import sha_pkg::*;
#(
    parameter int NumReq        = 4,
    parameter int BlockWidth    = BlockWidthDef,
    parameter int TimeoutCycles = TimeoutCyclesDef,
    parameter int IdxW          = $clog2(NumReq)
) (
    input  logic                             aclk_i,
    input  logic                             areset_ni,
    input  logic [NumReq-1:0]                req_valid_i,
    input  logic [NumReq-1:0]                req_first_i,
    input  logic [NumReq-1:0]                req_last_i,
    input  logic [NumReq-1:0][BlockWidth-1:0] req_block_i,
    output logic [NumReq-1:0]                req_ready_o,
    output logic [NumReq-1:0]                done_o,
    output logic [NumReq-1:0]                error_o,
    output logic [BlockWidth-1:0]            block_o,
    output logic                             enable_hash_o,
    output logic                             reset_hash_o,
    input  logic                             hold_i,
    input  logic                             idle_i,
    output logic                             busy_o,
    output logic [IdxW-1:0]                  grant_o
);

    localparam int CntW = $clog2(TimeoutCycles);
    // The abort is registered, so it is decided one cycle before the counter
    // would reach TimeoutCycles-1; the error pulse then lands in that cycle.
    localparam logic [CntW-1:0] CntAbort = CntW'(TimeoutCycles - 2);

    sched_state_e    state;
    logic [IdxW-1:0] ptr;
    logic            lock;
    logic            last_q;
    logic [CntW-1:0] cnt;

    logic [NumReq-1:0] arb_oh;
    logic [IdxW-1:0]   arb_idx;
    logic              arb_valid;
    logic [NumReq-1:0] grant_oh;

    assign grant_oh = {{(NumReq-1){1'b0}}, 1'b1} << grant_o;
    assign busy_o   = (state != ST_IDLE);

    rr_arbiter #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_arb (
        .req       (lock ? '0 : req_valid_i),
        .ptr       (ptr),
        .gnt_oh    (arb_oh),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    // Scheduler FSM: all pulse outputs are registered and default low each cycle.
    always_ff @(posedge aclk_i or negedge areset_ni) begin
        if (!areset_ni) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            lock          <= 1'b0;
            last_q        <= 1'b0;
            cnt           <= '0;
            grant_o       <= '0;
            block_o       <= '0;
            req_ready_o   <= '0;
            done_o        <= '0;
            error_o       <= '0;
            enable_hash_o <= 1'b0;
            reset_hash_o  <= 1'b0;
        end else begin
            req_ready_o   <= '0;
            done_o        <= '0;
            error_o       <= '0;
            enable_hash_o <= 1'b0;
            reset_hash_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_o     <= arb_idx;
                        req_ready_o <= arb_oh;
                        state       <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    block_o <= req_block_i[grant_o];
                    last_q  <= req_last_i[grant_o];
                    ptr     <= grant_o;
                    if (req_first_i[grant_o]) begin
                        reset_hash_o <= 1'b1;
                        state        <= ST_RESET;
                    end else begin
                        enable_hash_o <= 1'b1;
                        state         <= ST_LAUNCH;
                    end
                end
                ST_RESET: begin
                    enable_hash_o <= 1'b1;
                    state         <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    cnt   <= '0;
                    lock  <= 1'b1;
                    state <= ST_BUSY;
                end
                ST_BUSY: begin
                    cnt <= cnt + 1'b1;
                    // The core status lags launch by a cycle, so the first
                    // BUSY cycle never completes the job.
                    if (cnt != '0 && idle_i && !hold_i) begin
                        done_o <= grant_oh;
                        state  <= ST_DONE;
                    end else if (cnt == CntAbort) begin
                        error_o      <= grant_oh;
                        reset_hash_o <= 1'b1;
                        lock         <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (last_q) begin
                        lock  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_WAIT_NEXT;
                    end
                end
                ST_WAIT_NEXT: begin
                    if (req_valid_i[grant_o]) begin
                        req_ready_o <= grant_oh;
                        state       <= ST_ACCEPT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
